// File: rtl/shifter_seq32_pkg.sv
// Shared definitions for the multi-cycle shifter: operation codes and FSM states.
package shifter_seq32_pkg;

  localparam logic [1:0] ALU_SRA = 2'b00;
  localparam logic [1:0] ALU_SLA = 2'b01;
  localparam logic [1:0] ALU_SRL = 2'b10;
  localparam logic [1:0] ALU_SLL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shifter_seq32_if.sv
// Request/result bundle of the multi-cycle shifter.
interface shifter_seq32_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   b;
  logic [1:0]       aluc;
  logic [WIDTH-1:0] c;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, aluc,
    input  c, busy, done
  );

  modport slave (
    input  start, a, b, aluc,
    output c, busy, done
  );

endinterface

// File: rtl/shift_step32.sv
// Single-position shift of the accumulator, direction and fill chosen by op.
module shift_step32
  import shifter_seq32_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] acc_i,
  input  logic [1:0]       op_i,
  output logic [Width-1:0] acc_o
);

  // SLA and SLL are the same left shift; right shifts differ only in fill bit.
  always_comb begin
    acc_o = {acc_i[Width-2:0], 1'b0};
    case (op_i)
      ALU_SRA: acc_o = {acc_i[Width-1], acc_i[Width-1:1]};
      ALU_SRL: acc_o = {1'b0, acc_i[Width-1:1]};
      default: acc_o = {acc_i[Width-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/shifter_seq32.sv
// Multi-cycle shifter: captures operands on start, shifts one bit per clock,
// pulses done when the result register holds the final value.
module shifter_seq32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic           clk,
  input  logic           reset,
  shifter_seq32_if.slave bus
);

  import shifter_seq32_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  shift_step32 #(
    .Width (WIDTH)
  ) u_step (
    .acc_i (acc_q),
    .op_i  (op_q),
    .acc_o (acc_step)
  );

  // Next-state logic; busy/done are computed here so they leave as flops.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          acc_d = bus.a;
          op_d  = bus.aluc;
          cnt_d = bus.b;
          // A zero shift is complete as soon as the operand is captured.
          if (bus.b == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= ALU_SRA;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.c    = acc_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_shifter_seq32.sv
// Scoreboard bench for shifter_seq32: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_shifter_seq32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  shifter_seq32_if #(.WIDTH(32), .SHW(5)) bus ();

  shifter_seq32 #(
    .WIDTH (32),
    .SHW   (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] c;
    logic [31:0] cyc;
    logic [4:0]  b;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cyc    = 0;
  logic        prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] b,
                                            input logic [1:0] op);
    case (op)
      2'b00:   return 32'($signed(a) >>> b);
      2'b10:   return a >> b;
      default: return a << b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", bus.c, e.c);
        check("latency_cycle", cyc, e.cyc);
        // busy must fall as done rises, and was high beforehand only if shifting occurred.
        check("busy_edge", {30'd0, prev_busy, bus.busy}, {30'd0, (e.b != 0), 1'b0});
      end
    end
    prev_busy <= bus.busy;
  end

  // Called at a negedge; leaves at the following negedge with start dropped.
  task automatic issue(input logic [31:0] a, input logic [4:0] b, input logic [1:0] op,
                       input logic [31:0] exp);
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      check("busy_timeout", 32'd1, 32'd0);
      return;
    end
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.aluc  = op;
    // Accept edge is cyc+1; done is visible b cycles after it (same cycle if b is 0).
    sb_q.push_back('{exp, cyc + 1 + 32'(b), b});
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = 5'($urandom);
    bus.aluc  = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.aluc  = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_c", bus.c, 32'h0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(32'h8000_0000, 5'd4, 2'b00, 32'hF800_0000);
    drain();
    issue(32'h8000_0000, 5'd4, 2'b10, 32'h0800_0000);
    drain();
    issue(32'h0000_0001, 5'd31, 2'b11, 32'h8000_0000);
    issue(32'h0000_0001, 5'd31, 2'b01, 32'h8000_0000);
    drain();
    // Zero shift, then a request held while DONE is showing.
    issue(32'h1234_5678, 5'd0, 2'b00, 32'h1234_5678);
    issue(32'hFFFF_0000, 5'd8, 2'b00, 32'hFFFF_FF00);
    drain();

    // A start with different operands while busy must not disturb the operation.
    issue(32'h8000_0000, 5'd10, 2'b00, 32'hFFE0_0000);
    bus.start = 1'b1;
    bus.a     = 32'h0000_0001;
    bus.b     = 5'd1;
    bus.aluc  = 2'b11;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Reset two cycles into a long shift discards the operation.
    issue(32'hDEAD_BEEF, 5'd10, 2'b10, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_c", bus.c, 32'h0);
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    void'(sb_q.pop_back());
    repeat (3) @(negedge clk);
    check("post_reset_idle", {30'd0, bus.busy, bus.done}, 32'd0);

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra;
      logic [4:0]  rb;
      logic [1:0]  rop;
      ra  = $urandom;
      rb  = 5'($urandom_range(0, 31));
      rop = 2'($urandom_range(0, 3));
      issue(ra, rb, rop, ref_shift(ra, rb, rop));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
